// File: rtl/ysyx_22040895_ifetch_responder.sv
// Instruction-memory responder for the fetch stage.
// Accepts one fetch at a time over valid/ready and answers after LATENCY cycles.
// A flush (pc redirect) drops the in-flight request. Misaligned or out-of-range
// addresses return resp_err=1 with zero data. The memory is filled via the ld_* port.
module ysyx_22040895_ifetch_responder #(
    parameter int                ADDR_W  = 64,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] BASE    = 64'h8000_0000,
    parameter int                LATENCY = 2,
    localparam int               IDX_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              flush,
    input  logic              ld_we,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // First byte address past the end of the memory window.
    localparam logic [ADDR_W-1:0] LIMIT    = BASE + ADDR_W'(4 * DEPTH);
    // Wait-state count loaded on accept; unused when LATENCY is 1.
    localparam logic [2:0]        CNT_INIT = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        cnt_r;
    logic [2:0]        cnt_nxt_s;
    logic              resp_valid_r;
    logic [DATA_W-1:0] data_r;
    logic              err_r;

    logic              accept_s;
    logic              err_s;
    logic [IDX_W-1:0]  idx_s;

    // Ready depends only on state, flush and reset, never on req_valid.
    assign req_ready  = (state_r == IDLE) && !flush && !rst;
    assign accept_s   = req_valid && req_ready;

    assign resp_valid = resp_valid_r;
    assign resp_data  = data_r;
    assign resp_err   = err_r;

    // Address decode: alignment and window check, word index relative to BASE.
    always_comb begin
        err_s = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (req_addr >= LIMIT);
        idx_s = IDX_W'((req_addr - BASE) >> 2);
    end

    // Next-state logic: accept, wait countdown, response handshake, flush.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = CNT_INIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == 3'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // State, countdown and registered response-valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            resp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Capture the response at the accept edge; reads the pre-write memory word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
            err_r  <= 1'b0;
        end else if (accept_s) begin
            err_r  <= err_s;
            data_r <= err_s ? '0 : mem[idx_s];
        end
    end

    // Preload write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_ifetch_responder.sv
// Scoreboard bench for the fetch responder: expected words are predicted from a
// bench-side memory model when a request is driven and compared at the handshake.
module tb_ysyx_22040895_ifetch_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        flush;
    logic        ld_we;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    ysyx_22040895_ifetch_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .flush(flush), .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic [63:0] a);
        exp_t        e;
        logic [63:0] off;
        e.err = (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 64'(4 * DEPTH));
        off   = (a - BASE) >> 2;
        e.data = e.err ? 32'h0 : model[int'(off[11:0])];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_idx  = 12'(i);
        ld_data = d;
        tick();
        ld_we    = 1'b0;
        model[i] = d;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", {63'h0, req_ready}, 64'h1);
    endtask

    // Drive one request (optionally with a same-edge preload); push its prediction.
    task automatic issue(input logic [63:0] a, input bit ld, input int li, input logic [31:0] ld_d);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        if (ld) begin
            ld_we   = 1'b1;
            ld_idx  = 12'(li);
            ld_data = ld_d;
        end
        sb.push_back(predict(a));
        tick();
        req_valid = 1'b0;
        ld_we     = 1'b0;
        if (ld) model[li] = ld_d;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Check latency, hold stability, then pop and compare at the handshake.
    task automatic respond(input int hold);
        int   lat;
        exp_t e;
        wait_valid(lat);
        check("latency", 64'(lat), 64'(LAT));
        check("sb_nonempty", {63'h0, sb.size() != 0}, 64'h1);
        if (sb.size() != 0) begin
            for (int k = 0; k < hold; k++) begin
                check("hold_valid", {63'h0, resp_valid}, 64'h1);
                check("hold_ready", {63'h0, req_ready}, 64'h0);
                check("hold_data", {32'h0, resp_data}, {32'h0, sb[0].data});
                tick();
            end
            e = sb.pop_front();
            check("resp_data", {32'h0, resp_data}, {32'h0, e.data});
            check("resp_err", {63'h0, resp_err}, {63'h0, e.err});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("post_valid", {63'h0, resp_valid}, 64'h0);
        check("post_ready", {63'h0, req_ready}, 64'h1);
    endtask

    task automatic fetch(input logic [63:0] a, input int hold);
        issue(a, 1'b0, 0, 32'h0);
        respond(hold);
    endtask

    initial begin
        int   seen;
        int   lat;
        exp_t drop;
        rst = 1'b1; req_valid = 1'b0; req_addr = 64'h0; resp_ready = 1'b0;
        flush = 1'b0; ld_we = 1'b0; ld_idx = 12'h0; ld_data = 32'h0;
        #1;
        check("rst_valid", {63'h0, resp_valid}, 64'h0);
        check("rst_data", {32'h0, resp_data}, 64'h0);
        check("rst_err", {63'h0, resp_err}, 64'h0);
        check("rst_ready", {63'h0, req_ready}, 64'h0);
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check("idle_ready", {63'h0, req_ready}, 64'h1);

        // Basic fetch and preloaded words
        preload(0, 32'h0000_0413);
        preload(1, 32'h1234_5678);
        preload(3, 32'h0BAD_F00D);
        preload(4095, 32'hCAFE_0001);
        fetch(BASE, 0);

        // Fault cases and the last legal word
        fetch(BASE + 64'h2, 0);
        fetch(64'h7FFF_FFFC, 0);
        fetch(BASE + 64'(4 * DEPTH), 0);
        fetch(BASE + 64'(4 * DEPTH) - 64'h4, 0);

        // Backpressure: hold resp_ready low for 5 cycles
        fetch(BASE + 64'h4, 5);

        // Flush in WAIT: no response, then a normal fetch
        wait_ready();
        req_valid = 1'b1; req_addr = BASE + 64'h4;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (resp_valid) seen++;
            tick();
        end
        check("flush_wait", 64'(seen), 64'h0);
        fetch(BASE + 64'h4, 0);

        // Flush in RESP overrides resp_ready
        issue(BASE, 1'b0, 0, 32'h0);
        wait_valid(lat);
        check("flush_resp_lat", 64'(lat), 64'(LAT));
        flush = 1'b1; resp_ready = 1'b1;
        tick();
        flush = 1'b0; resp_ready = 1'b0;
        check("flush_resp_valid", {63'h0, resp_valid}, 64'h0);
        if (sb.size() != 0) drop = sb.pop_front();

        // Flush in IDLE blocks acceptance
        flush = 1'b1; req_valid = 1'b1; req_addr = BASE;
        #1;
        check("flush_idle_ready", {63'h0, req_ready}, 64'h0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (resp_valid) seen++;
            tick();
        end
        check("flush_idle_noresp", 64'(seen), 64'h0);

        // Same-edge preload returns the old word, then the new one
        issue(BASE + 64'hC, 1'b1, 3, 32'hDEAD_BEEF);
        respond(0);
        fetch(BASE + 64'hC, 0);

        // Async reset mid-WAIT
        issue(BASE, 1'b0, 0, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("rstw_valid", {63'h0, resp_valid}, 64'h0);
        check("rstw_ready", {63'h0, req_ready}, 64'h0);
        if (sb.size() != 0) drop = sb.pop_back();
        tick();
        rst = 1'b0;

        // Async reset mid-RESP
        issue(BASE + 64'hC, 1'b0, 0, 32'h0);
        wait_valid(lat);
        check("rstr_lat", 64'(lat), 64'(LAT));
        #2 rst = 1'b1;
        #1;
        check("rstr_valid", {63'h0, resp_valid}, 64'h0);
        check("rstr_ready", {63'h0, req_ready}, 64'h0);
        check("rstr_data", {32'h0, resp_data}, 64'h0);
        if (sb.size() != 0) drop = sb.pop_back();
        tick();
        rst = 1'b0;

        // Memory survives reset
        fetch(BASE, 0);
        fetch(BASE + 64'hC, 0);
        fetch(BASE + 64'h4, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
